// File: rtl/router_pkg.sv
// Shared router definitions: packet width, token packet, arbiter state and
// requester ID encodings, plus a requester-ID to ack-vector helper.
package router_pkg;

    localparam int PKT_W = 55;

    localparam logic [PKT_W-1:0] TOKEN_PKT = 55'h2A_5A5A_C3C3_0F0F;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD        = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } arb_state_e;

    localparam logic [1:0] ID_FWD  = 2'd0;
    localparam logic [1:0] ID_NODE = 2'd1;
    localparam logic [1:0] ID_TOK  = 2'd2;

    // Ack vector bit order is {Tok, Node, Fwd}
    function automatic logic [2:0] ack_onehot(input logic [1:0] id);
        logic [2:0] vec;
        case (id)
            ID_FWD:  vec = 3'b001;
            ID_NODE: vec = 3'b010;
            ID_TOK:  vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way combinational round-robin picker; the search starts at the
// requester following the one granted last.
module rr_arb3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;
    logic [3:0] req_pad_s;

    assign req_pad_s = {1'b0, req};

    // Rotate the search order behind the last grant
    always_comb begin
        case (last)
            ID_FWD: begin
                first_s  = ID_NODE;
                second_s = ID_TOK;
                third_s  = ID_FWD;
            end
            ID_NODE: begin
                first_s  = ID_TOK;
                second_s = ID_FWD;
                third_s  = ID_NODE;
            end
            default: begin
                first_s  = ID_FWD;
                second_s = ID_NODE;
                third_s  = ID_TOK;
            end
        endcase
    end

    // First active requester in rotated order wins
    always_comb begin
        grant = first_s;
        any   = 1'b0;
        if (req_pad_s[first_s]) begin
            grant = first_s;
            any   = 1'b1;
        end else if (req_pad_s[second_s]) begin
            grant = second_s;
            any   = 1'b1;
        end else if (req_pad_s[third_s]) begin
            grant = third_s;
            any   = 1'b1;
        end else begin
            grant = first_s;
            any   = 1'b0;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Transmit arbiter: round-robin grant between forward, node and token
// requesters, then a valid/ready handshake and shift-completion wait.
module tx_arbiter
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             Clk_R,
    input  logic             Rst_n,
    input  logic             Fwd_Req,
    input  logic [PKT_W-1:0] Fwd_Data,
    input  logic             Node_Req,
    input  logic [PKT_W-1:0] Node_Data,
    input  logic             Tok_Req,
    output logic             Fwd_Ack,
    output logic             Node_Ack,
    output logic             Tok_Ack,
    input  logic             TX_Data_Ready,
    output logic             TX_Data_Valid,
    output logic [PKT_W-1:0] TX_Data,
    output logic             Tx_Err,
    output logic [15:0]      Pkt_Count
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_r;
    arb_state_e       state_s;
    logic [1:0]       grant_r;
    logic [1:0]       grant_s;
    logic [PKT_W-1:0] tx_data_r;
    logic [PKT_W-1:0] tx_data_s;
    logic             tx_valid_r;
    logic             tx_valid_s;
    logic [2:0]       ack_r;
    logic [2:0]       ack_s;
    logic             err_r;
    logic             err_s;
    logic [15:0]      pkt_count_r;
    logic [15:0]      pkt_count_s;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_s;
    logic             seen_low_r;
    logic             seen_low_s;

    logic [1:0]       arb_grant_s;
    logic             arb_any_s;
    logic             can_grant_s;
    logic             wa_hs_s;
    logic             wa_to_s;
    logic             wd_done_s;

    rr_arb3 u_rr_arb3 (
        .req   ({Tok_Req, Node_Req, Fwd_Req}),
        .last  (grant_r),
        .grant (arb_grant_s),
        .any   (arb_any_s)
    );

    // No grant while an ack is out, so the acked requester can drop its request
    assign can_grant_s = arb_any_s & (ack_r == 3'b000);
    assign wa_hs_s     = (state_r == ST_WAIT_ACCEPT) & TX_Data_Ready;
    assign wa_to_s     = (state_r == ST_WAIT_ACCEPT) & ~TX_Data_Ready & (cnt_r == TO_LAST);
    assign wd_done_s   = (state_r == ST_WAIT_DONE) & TX_Data_Ready &
                         (seen_low_r | (cnt_r == TO_LAST));

    // State register
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (can_grant_s) state_s = ST_LOAD;
                else             state_s = ST_IDLE;
            end
            ST_LOAD: state_s = ST_WAIT_ACCEPT;
            ST_WAIT_ACCEPT: begin
                if (wa_hs_s)      state_s = ST_WAIT_DONE;
                else if (wa_to_s) state_s = ST_IDLE;
                else              state_s = ST_WAIT_ACCEPT;
            end
            ST_WAIT_DONE: begin
                if (wd_done_s) state_s = ST_IDLE;
                else           state_s = ST_WAIT_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        grant_s     = grant_r;
        tx_data_s   = tx_data_r;
        tx_valid_s  = tx_valid_r;
        ack_s       = 3'b000;
        err_s       = err_r;
        pkt_count_s = pkt_count_r;
        cnt_s       = cnt_r;
        seen_low_s  = seen_low_r;
        case (state_r)
            ST_IDLE: begin
                if (can_grant_s) begin
                    grant_s = arb_grant_s;
                    case (arb_grant_s)
                        ID_FWD:  tx_data_s = Fwd_Data;
                        ID_NODE: tx_data_s = Node_Data;
                        default: tx_data_s = TOKEN_PKT;
                    endcase
                end else begin
                    grant_s = grant_r;
                end
            end
            ST_LOAD: begin
                tx_valid_s = 1'b1;
                cnt_s      = 16'd0;
            end
            ST_WAIT_ACCEPT: begin
                if (wa_hs_s) begin
                    tx_valid_s = 1'b0;
                    cnt_s      = 16'd0;
                    seen_low_s = 1'b0;
                end else if (wa_to_s) begin
                    tx_valid_s = 1'b0;
                    err_s      = 1'b1;
                    ack_s      = ack_onehot(grant_r);
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (wd_done_s) begin
                    ack_s       = ack_onehot(grant_r);
                    pkt_count_s = pkt_count_r + 16'd1;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                    if (!TX_Data_Ready) seen_low_s = 1'b1;
                    else                seen_low_s = seen_low_r;
                end
            end
            default: begin
                tx_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            grant_r     <= ID_TOK;
            tx_data_r   <= '0;
            tx_valid_r  <= 1'b0;
            ack_r       <= 3'b000;
            err_r       <= 1'b0;
            pkt_count_r <= 16'd0;
            cnt_r       <= 16'd0;
            seen_low_r  <= 1'b0;
        end else begin
            grant_r     <= grant_s;
            tx_data_r   <= tx_data_s;
            tx_valid_r  <= tx_valid_s;
            ack_r       <= ack_s;
            err_r       <= err_s;
            pkt_count_r <= pkt_count_s;
            cnt_r       <= cnt_s;
            seen_low_r  <= seen_low_s;
        end
    end

    assign TX_Data_Valid = tx_valid_r;
    assign TX_Data       = tx_data_r;
    assign Fwd_Ack       = ack_r[0];
    assign Node_Ack      = ack_r[1];
    assign Tok_Ack       = ack_r[2];
    assign Tx_Err        = err_r;
    assign Pkt_Count     = pkt_count_r;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max Clk_R cycles to wait for transmitter acceptance; legal range 1..65535.
REQ-002 Clk_R  in  1  router core clock; the only clock; all logic on rising edge.
REQ-003 Rst_n  in  1  asynchronous active-low reset.
REQ-004 Fwd_Req  in  1  forward path requests to send Fwd_Data; held until Fwd_Ack.
REQ-005 Fwd_Data  in  55  packet to forward; stable while Fwd_Req high.
REQ-006 Node_Req  in  1  local node requests to send Node_Data; held until Node_Ack.
REQ-007 Node_Data  in  55  encoded node packet; stable while Node_Req high.
REQ-008 Tok_Req  in  1  request to emit token packet TOKEN_PKT; held until Tok_Ack.
REQ-009 Fwd_Ack, Node_Ack, Tok_Ack  out  1 each  one-cycle pulse: requester's packet fully transmitted or abandoned.
REQ-010 TX_Data_Ready  in  1  transmitter idle; already synchronous to Clk_R.
REQ-011 TX_Data_Valid  out  1  TX_Data valid for transmitter.
REQ-012 TX_Data  out  55  packet to transmitter.
REQ-013 Tx_Err  out  1  sticky: a timeout occurred; cleared only by reset.
REQ-014 Pkt_Count  out  16  packets sent successfully, wraps 0xFFFF->0.

Function
REQ-015 States: IDLE, LOAD, WAIT_ACCEPT, WAIT_DONE.
REQ-016 IDLE: if any request high, grant per round-robin, latch selected packet into TX_Data, go LOAD; else stay.
REQ-017 Round-robin order Fwd->Node->Tok; search starts at requester after last granted; after reset last granted = Tok (Fwd first).
REQ-018 Pointer updates only on grant; simultaneous requests resolved by pointer alone.
REQ-019 LOAD: assert TX_Data_Valid next cycle, go WAIT_ACCEPT; TX_Data constant from LOAD through WAIT_DONE exit.
REQ-020 WAIT_ACCEPT: TX_Data_Valid high; handshake = TX_Data_Valid & TX_Data_Ready on a rising edge; then deassert TX_Data_Valid next cycle, go WAIT_DONE.
REQ-021 WAIT_DONE: wait for TX_Data_Ready low then high again (shift complete); on that high cycle pulse granted Ack, increment Pkt_Count, go IDLE.
REQ-022 If TX_Data_Ready never drops in WAIT_DONE for TIMEOUT_CYCLES cycles, treat as done (same as REQ-021).
REQ-023 Timeout counter (16 bit) clears on entry to WAIT_ACCEPT and WAIT_DONE, counts each cycle in those states.
REQ-024 WAIT_ACCEPT timeout (count == TIMEOUT_CYCLES, no handshake): drop TX_Data_Valid, set Tx_Err, pulse granted Ack, Pkt_Count unchanged, go IDLE.
REQ-025 Minimum request-to-request spacing: IDLE one cycle after every Ack; no back-to-back grant without IDLE.
REQ-026 Request deasserted mid-transfer: ignored; transfer completes, Ack still pulses.
REQ-027 At most one Ack high in any cycle; Ack only to granted requester.
REQ-028 Grant latched in 2-bit register; outputs registered (no combinational input->output path).

Reset
REQ-029 Rst_n low: state IDLE, TX_Data_Valid 0, TX_Data 0, all Acks 0, Tx_Err 0, Pkt_Count 0, timeout counter 0, last-granted = Tok.
REQ-030 Reset mid-transfer aborts immediately; no Ack issued; transmitter sees TX_Data_Valid fall asynchronously.

Structure
REQ-031 Shared package router_pkg holds PKT_W = 55, TOKEN_PKT constant, arbiter state encoding, requester ID encoding (FWD=0, NODE=1, TOK=2).
REQ-032 One sub-module rr_arb3: 3-request combinational round-robin picker (req[2:0], last[1:0] -> grant[1:0], any).

Verification
REQ-033 Fwd_Req only, Fwd_Data=55'h0123456789ABCD, TX_Data_Ready high, drops 2 cycles after accept for 10 cycles -> TX_Data equals Fwd_Data, Fwd_Ack pulses once, Pkt_Count=1.
REQ-034 Fwd, Node, Tok all held continuously for 6 packets -> grant order Fwd,Node,Tok,Fwd,Node,Tok; Pkt_Count=6.
REQ-035 Node_Req, TX_Data_Ready held low, TIMEOUT_CYCLES=8 -> TX_Data_Valid drops after 8 WAIT_ACCEPT cycles, Tx_Err=1, Node_Ack pulses, Pkt_Count=0.
REQ-036 Rst_n low during WAIT_DONE -> all outputs reset values next edge-free instant, no Ack; after release Fwd granted first.
REQ-037 Pkt_Count preloaded via 65535 sends (or forced) -> next success wraps to 0.
REQ-038 Tok_Req alone -> TX_Data equals TOKEN_PKT, Tok_Ack pulses once.
